// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the scan controller and the 8-to-1 mux / request logic.
// The master is the controller; the slave is the mux plus whoever issues requests.
interface mux_scan_ctrl_if;
    logic       start;
    logic       continuous;
    logic       abort;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic [7:0] data;

    modport master (
        input  start, continuous, abort, y,
        output a, b, c, busy, done, data
    );

    modport slave (
        output start, continuous, abort, y,
        input  a, b, c, busy, done, data
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8-to-1 mux select through channels 0..7, samples y once per channel
// and publishes the eight samples as one registered byte with a done pulse.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_scan_ctrl_if.master     bus
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(7);

    logic [1:0]        state_q,  state_d;
    logic [SEL_W-1:0]  sel_q,    sel_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              done_q,   done_d;
    logic              busy_q,   busy_d;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                shadow_d[sel_q] = bus.y;
                if (sel_q == SEL_LAST) begin
                    // Publish including the bit captured on this same edge
                    state_d = ST_DONE;
                    data_d  = shadow_d;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    sel_d   = sel_q + SEL_W'(1);
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                sel_d = '0;
                if (bus.continuous) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase

        // Abort overrides every transition; the published byte is kept
        if (bus.abort) begin
            state_d  = ST_IDLE;
            sel_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
            data_d   = data_q;
            done_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.a    = sel_q[0];
    assign bus.b    = sel_q[1];
    assign bus.c    = sel_q[2];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Scan controller that sits directly upstream and downstream of the 8-to-1 mux. It drives the mux select lines `{c,b,a}` through channels 0..7 and samples the mux output `y` once per channel. The eight samples are assembled into one parallel byte. This turns eight slow single-bit inputs behind the mux into one registered word with a done pulse, for single-shot or continuous scanning.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each select value is held before its sample cycle. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin a scan; honoured only in IDLE.
- `continuous`  in  1  when high at the end of a scan, the next scan starts immediately.
- `abort`  in  1  synchronous; ends any scan in progress and returns to IDLE.
- `y`  in  1  mux output being scanned.
- `a`  out  1  select bit 0 (LSB) to the mux.
- `b`  out  1  select bit 1 to the mux.
- `c`  out  1  select bit 2 (MSB) to the mux.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `data` is valid and updated in that same cycle.
- `data`  out  8  last completed scan; `data[i]` is `y` sampled while `{c,b,a}==i`.

## Operation
- States:
  - IDLE: waits for a request.
  - SETTLE: holds the current select value while `cnt` counts `SETTLE_CYCLES`.
  - SAMPLE: one cycle; `y` is captured at the end of it.
  - DONE: one cycle that publishes the result.
- Internal registers: 3-bit `sel` driving `{c,b,a}`, an 8-bit `cnt`, and an 8-bit `shadow`.
- IDLE:
  - `sel`=0.
  - If `start`=1 and `abort`=0, go to SETTLE with `cnt`=0.
- SETTLE:
  - `cnt` increments each cycle.
  - When `cnt==SETTLE_CYCLES-1`, go to SAMPLE.
- SAMPLE:
  - At the end of the cycle, `shadow[sel]` <= `y`.
  - If `sel`==7, go to DONE.
  - Otherwise `sel` <= `sel`+1, `cnt` <= 0, and go to SETTLE.
- DONE:
  - `data` = `shadow` and `done` = 1 are both registered, so they are visible during the DONE cycle.
  - `sel` <= 0.
  - If `continuous`=1 and `abort`=0, go to SETTLE with `cnt`=0. Otherwise go to IDLE.
- `start` is ignored outside IDLE. No queuing, no restart.
- `continuous` is examined only in DONE. Deasserting it mid-scan lets the current scan complete.
- `abort`:
  - Has priority over every transition, including `start` in the same cycle.
  - Next state is IDLE with `sel`=0.
  - Partial `shadow` contents are discarded.
  - `data` is unchanged and `done` is not pulsed.
  - An abort raised during DONE does not cancel that cycle's `done` pulse. It only blocks a continuous restart.
- `sel` does not wrap. It counts 0..7 and is reset to 0 in DONE, IDLE or on abort.

## Timing
- Reset values (asynchronous, immediately on `rst_n`=0):
  - state IDLE.
  - `a`=`b`=`c`=0.
  - `busy`=0, `done`=0, `data`=8'h00, `shadow`=0, `cnt`=0.
- Reset mid-scan discards all progress. Operation resumes from IDLE on the first edge after `rst_n` rises.
- Each channel occupies S+1 cycles, where S=`SETTLE_CYCLES`. The select value is stable for S full cycles before the capture cycle, plus the capture cycle itself.
- Latency: `start` is sampled at edge k. `done` is high in the cycle following edge k+8(S+1). For S=2 that is 24 cycles after the start edge.
- Continuous mode: `done` period is 8(S+1)+1 cycles, which is 25 for S=2.
- `busy`:
  - Rises at the edge that accepts `start`.
  - Falls at the edge leaving DONE to IDLE, or at the abort edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Mux inputs d0..d7 = bits of 8'hA5, S=2, one-cycle `start` → `{c,b,a}` steps 0..7 with each value held 3 cycles; `done` high exactly 24 cycles after the start edge for one cycle; `data`=8'hA5; `busy` low the cycle after DONE.
- Same setup, second `start` pulse 10 cycles into the scan → exactly one `done` at cycle 24; select sequence not disturbed; no second scan.
- `continuous`=1, inputs 8'h3C, switched to 8'hC3 right after the first `done` → `done` pulses 25 cycles apart; `data`=8'h3C, then 8'hC3; `busy` stays high throughout.
- After a completed scan with `data`=8'hA5, inputs changed to 8'hFF and a new scan started, `abort` at cycle 12 → `busy` and `{c,b,a}` go to 0 at the next edge; no `done`; `data` stays 8'hA5.
- `rst_n` pulsed low asynchronously between edges mid-scan → all outputs read 0 before the next edge; a fresh `start` afterwards completes normally in 24 cycles.
- In IDLE, `start`=1 and `abort`=1 in the same cycle → stays IDLE with `busy`=0. Scan with S=1 → `done` arrives 16 cycles after start.
